// File: rtl/uart_multi_reg_if.sv
// DSP bus bundle for the UART register bank: chip enable, read/write select,
// channel/offset address, write data and registered read data.
interface uart_multi_reg_if #(
    parameter int unsigned CH_W = 2
);
    logic            dsp_cen;
    logic            dsp_wen;
    logic [CH_W+3:0] dsp_addr;
    logic [31:0]     dsp_wdata;
    logic [31:0]     dsp_rdata;

    modport master (
        output dsp_cen,
        output dsp_wen,
        output dsp_addr,
        output dsp_wdata,
        input  dsp_rdata
    );

    modport slave (
        input  dsp_cen,
        input  dsp_wen,
        input  dsp_addr,
        input  dsp_wdata,
        output dsp_rdata
    );
endinterface

// File: rtl/uart_multi_reg.sv
// Multi-channel UART register bank. Per channel: LCR/FCR/ER/IBRD/FBRD control,
// sampled status (SR), sticky W1C error flags (RIS), interrupt mask (IMR) and a
// registered per-channel interrupt; UART_IRQ is the registered OR of all channels.
module uart_multi_reg #(
    parameter int unsigned NUM_CH = 4,
    parameter int unsigned CH_W   = 2,
    parameter int unsigned BRD_W  = 16
) (
    input  logic                    i_dsp_clk,
    input  logic                    i_reset,
    uart_multi_reg_if.slave         io_bus,
    output logic [2*NUM_CH-1:0]     o_parity,
    output logic [NUM_CH-1:0]       o_stop_bits,
    output logic [3*NUM_CH-1:0]     o_data_bits,
    output logic [NUM_CH-1:0]       o_fifo_en,
    output logic [NUM_CH-1:0]       o_uart_en,
    output logic [NUM_CH-1:0]       o_rx_en,
    output logic [NUM_CH-1:0]       o_tx_en,
    output logic [4*NUM_CH-1:0]     o_rx_fifol,
    output logic [4*NUM_CH-1:0]     o_tx_fifol,
    output logic [BRD_W*NUM_CH-1:0] o_ibrd_val,
    output logic [6*NUM_CH-1:0]     o_fbrd_val,
    input  logic [NUM_CH-1:0]       i_parity_err,
    input  logic [NUM_CH-1:0]       i_frame_err,
    input  logic [NUM_CH-1:0]       i_overrun_err,
    input  logic [NUM_CH-1:0]       i_rx_empty,
    input  logic [NUM_CH-1:0]       i_rx_full,
    input  logic [NUM_CH-1:0]       i_tx_empty,
    input  logic [NUM_CH-1:0]       i_tx_full,
    output logic [NUM_CH-1:0]       o_ch_irq,
    output logic                    o_uart_irq
);

    localparam logic [3:0] OffLcr  = 4'h1;
    localparam logic [3:0] OffFcr  = 4'h2;
    localparam logic [3:0] OffEr   = 4'h3;
    localparam logic [3:0] OffSr   = 4'h4;
    localparam logic [3:0] OffRis  = 4'h5;
    localparam logic [3:0] OffImr  = 4'h6;
    localparam logic [3:0] OffIbrd = 4'h7;
    localparam logic [3:0] OffFbrd = 4'h8;
    localparam logic [3:0] OffMis  = 4'h9;

    logic [5:0]       r_lcr  [NUM_CH];
    logic [7:0]       r_fcr  [NUM_CH];
    logic [2:0]       r_er   [NUM_CH];
    logic [7:0]       r_sr   [NUM_CH];
    logic [2:0]       r_ris  [NUM_CH];
    logic [2:0]       r_imr  [NUM_CH];
    logic [BRD_W-1:0] r_ibrd [NUM_CH];
    logic [5:0]       r_fbrd [NUM_CH];
    logic [31:0]      r_rdata;
    logic [NUM_CH-1:0] r_ch_irq;
    logic             r_uart_irq;

    logic [CH_W-1:0]   w_ch;
    logic [3:0]        w_off;
    logic              w_wr;
    logic              w_rd;
    logic [NUM_CH-1:0] w_sel;
    logic [31:0]       w_rd_val;
    logic [2:0]        w_mis  [NUM_CH];
    logic [NUM_CH-1:0] w_irq_d;
    logic              w_unused;

    assign w_ch     = io_bus.dsp_addr[CH_W+3:4];
    assign w_off    = io_bus.dsp_addr[3:0];
    assign w_wr     = ~io_bus.dsp_cen & ~io_bus.dsp_wen;
    assign w_rd     = ~io_bus.dsp_cen &  io_bus.dsp_wen;
    // Not every write-data bit lands in a register for every BRD_W.
    assign w_unused = ^io_bus.dsp_wdata;

    // Decode channel select; codes at or above NUM_CH select nothing.
    always_comb begin
        w_sel = '0;
        for (int n = 0; n < NUM_CH; n++) begin
            if (w_ch == CH_W'(n)) begin
                w_sel[n] = 1'b1;
            end
        end
    end

    // Masked interrupt status per channel and next-state interrupt lines.
    always_comb begin
        for (int n = 0; n < NUM_CH; n++) begin
            w_mis[n]   = r_ris[n] & r_imr[n];
            w_irq_d[n] = |w_mis[n];
        end
    end

    // Read multiplexer; unselected channels and unused offsets return 0.
    always_comb begin
        w_rd_val = '0;
        for (int n = 0; n < NUM_CH; n++) begin
            if (w_sel[n]) begin
                case (w_off)
                    OffLcr:  w_rd_val = 32'(r_lcr[n]);
                    OffFcr:  w_rd_val = 32'(r_fcr[n]);
                    OffEr:   w_rd_val = 32'(r_er[n]);
                    OffSr:   w_rd_val = 32'(r_sr[n]);
                    OffRis:  w_rd_val = 32'(r_ris[n]);
                    OffImr:  w_rd_val = 32'(r_imr[n]);
                    OffIbrd: w_rd_val = 32'(r_ibrd[n]);
                    OffFbrd: w_rd_val = 32'(r_fbrd[n]);
                    OffMis:  w_rd_val = 32'(w_mis[n]);
                    default: w_rd_val = '0;
                endcase
            end
        end
    end

    // Control registers, status sampling and sticky error flags.
    always_ff @(posedge i_dsp_clk) begin
        if (i_reset) begin
            for (int n = 0; n < NUM_CH; n++) begin
                r_lcr[n]  <= '0;
                r_fcr[n]  <= '0;
                r_er[n]   <= '0;
                r_sr[n]   <= '0;
                r_ris[n]  <= '0;
                r_imr[n]  <= '0;
                r_ibrd[n] <= '0;
                r_fbrd[n] <= '0;
            end
        end else begin
            for (int n = 0; n < NUM_CH; n++) begin
                r_sr[n] <= {i_tx_full[n], i_tx_empty[n], i_rx_full[n], i_rx_empty[n],
                            1'b0, i_overrun_err[n], i_frame_err[n], i_parity_err[n]};
                // Clear first, then OR in the set so a simultaneous set wins.
                if (w_wr && w_sel[n] && (w_off == OffRis)) begin
                    r_ris[n] <= (r_ris[n] & ~io_bus.dsp_wdata[2:0]) | r_sr[n][2:0];
                end else begin
                    r_ris[n] <= r_ris[n] | r_sr[n][2:0];
                end
                if (w_wr && w_sel[n]) begin
                    case (w_off)
                        OffLcr:  r_lcr[n]  <= io_bus.dsp_wdata[5:0];
                        OffFcr:  r_fcr[n]  <= io_bus.dsp_wdata[7:0];
                        OffEr:   r_er[n]   <= io_bus.dsp_wdata[2:0];
                        OffImr:  r_imr[n]  <= io_bus.dsp_wdata[2:0];
                        OffIbrd: r_ibrd[n] <= io_bus.dsp_wdata[BRD_W-1:0];
                        OffFbrd: r_fbrd[n] <= io_bus.dsp_wdata[5:0];
                        default: ;
                    endcase
                end
            end
        end
    end

    // Registered read data (held when idle) and registered interrupts.
    always_ff @(posedge i_dsp_clk) begin
        if (i_reset) begin
            r_rdata    <= '0;
            r_ch_irq   <= '0;
            r_uart_irq <= 1'b0;
        end else begin
            if (w_rd) begin
                r_rdata <= w_rd_val;
            end
            r_ch_irq   <= w_irq_d;
            r_uart_irq <= |w_irq_d;
        end
    end

    assign io_bus.dsp_rdata = r_rdata;
    assign o_ch_irq         = r_ch_irq;
    assign o_uart_irq       = r_uart_irq;

    for (genvar g = 0; g < NUM_CH; g++) begin : g_out
        assign o_parity[2*g +: 2]        = r_lcr[g][1:0];
        assign o_stop_bits[g]            = r_lcr[g][2];
        // LCR[4:3] 00..11 encodes 4..7 data bits.
        assign o_data_bits[3*g +: 3]     = {1'b1, r_lcr[g][4:3]};
        assign o_fifo_en[g]              = r_lcr[g][5];
        assign o_uart_en[g]              = r_er[g][0];
        assign o_rx_en[g]                = r_er[g][1];
        assign o_tx_en[g]                = r_er[g][2];
        assign o_rx_fifol[4*g +: 4]      = r_fcr[g][3:0];
        assign o_tx_fifol[4*g +: 4]      = r_fcr[g][7:4];
        assign o_ibrd_val[BRD_W*g +: BRD_W] = r_ibrd[g];
        assign o_fbrd_val[6*g +: 6]      = r_fbrd[g];
    end

endmodule

// File: tb/tb_uart_multi_reg.sv
// Directed bench for uart_multi_reg (NUM_CH=4, CH_W=2, BRD_W=16).
module tb_uart_multi_reg;

    logic        clk = 1'b0;
    logic        rst;
    logic [7:0]  parity;
    logic [3:0]  stop_bits;
    logic [11:0] data_bits;
    logic [3:0]  fifo_en, uart_en, rx_en, tx_en;
    logic [15:0] rx_fifol, tx_fifol;
    logic [63:0] ibrd_val;
    logic [23:0] fbrd_val;
    logic [3:0]  pe, fe, oe, rxe, rxf, txe, txf;
    logic [3:0]  ch_irq;
    logic        uart_irq;
    logic [31:0] rd;
    int          tests = 0;
    int          fails = 0;

    uart_multi_reg_if #(.CH_W(2)) bus ();

    uart_multi_reg #(.NUM_CH(4), .CH_W(2), .BRD_W(16)) dut (
        .i_dsp_clk     (clk),
        .i_reset       (rst),
        .io_bus        (bus),
        .o_parity      (parity),
        .o_stop_bits   (stop_bits),
        .o_data_bits   (data_bits),
        .o_fifo_en     (fifo_en),
        .o_uart_en     (uart_en),
        .o_rx_en       (rx_en),
        .o_tx_en       (tx_en),
        .o_rx_fifol    (rx_fifol),
        .o_tx_fifol    (tx_fifol),
        .o_ibrd_val    (ibrd_val),
        .o_fbrd_val    (fbrd_val),
        .i_parity_err  (pe),
        .i_frame_err   (fe),
        .i_overrun_err (oe),
        .i_rx_empty    (rxe),
        .i_rx_full     (rxf),
        .i_tx_empty    (txe),
        .i_tx_full     (txf),
        .o_ch_irq      (ch_irq),
        .o_uart_irq    (uart_irq)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic bus_write(input int ch, input int off, input logic [31:0] data);
        @(negedge clk);
        bus.dsp_cen   = 1'b0;
        bus.dsp_wen   = 1'b0;
        bus.dsp_addr  = {ch[1:0], off[3:0]};
        bus.dsp_wdata = data;
        @(negedge clk);
        bus.dsp_cen   = 1'b1;
        bus.dsp_wen   = 1'b1;
    endtask

    task automatic bus_read(input int ch, input int off, output logic [31:0] data);
        @(negedge clk);
        bus.dsp_cen  = 1'b0;
        bus.dsp_wen  = 1'b1;
        bus.dsp_addr = {ch[1:0], off[3:0]};
        @(negedge clk);
        bus.dsp_cen  = 1'b1;
        data = bus.dsp_rdata;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1;
        {pe, fe, oe, rxe, rxf, txe, txf} = '0;
        bus.dsp_cen   = 1'b1;
        bus.dsp_wen   = 1'b1;
        bus.dsp_addr  = '0;
        bus.dsp_wdata = '0;
        repeat (3) @(negedge clk);
        rst = 1'b0;

        // 1: reset state, every offset of every channel reads 0
        for (int c = 0; c < 4; c++) begin
            for (int o = 0; o < 16; o++) begin
                bus_read(c, o, rd);
                check($sformatf("rst_rd_c%0d_o%0d", c, o), rd, 32'h0);
            end
        end
        check("rst_data_bits", 32'(data_bits), 32'h924);
        check("rst_ch_irq", 32'(ch_irq), 32'h0);
        check("rst_uart_irq", 32'(uart_irq), 32'h0);

        // 2: LCR ch2 = 0x3B
        bus_write(2, 1, 32'h3B);
        bus_read(2, 1, rd);
        check("lcr2_rd", rd, 32'h3B);
        check("lcr2_parity", 32'(parity), 32'h30);
        check("lcr2_stop", 32'(stop_bits), 32'h0);
        check("lcr2_data_bits", 32'(data_bits), 32'h9E4);
        check("lcr2_fifo_en", 32'(fifo_en), 32'h4);

        // 3: frame error on ch1 with IMR bit 1 set
        bus_write(1, 6, 32'h2);
        @(negedge clk);
        fe = 4'b0010;              // sampled at the next rising edge E
        @(negedge clk);
        fe = 4'b0000;              // after E: SR holds FE
        check("fe_irq_e0", 32'(ch_irq), 32'h0);
        @(negedge clk);            // after E+1: RIS set
        check("fe_irq_e1", 32'(ch_irq), 32'h0);
        @(negedge clk);            // after E+2: CH_IRQ set
        check("fe_irq_e2", 32'(ch_irq), 32'h2);
        check("fe_uart_irq", 32'(uart_irq), 32'h1);
        bus_read(1, 5, rd);
        check("fe_ris1", rd, 32'h2);
        bus_read(1, 9, rd);
        check("fe_mis1", rd, 32'h2);
        bus_write(1, 5, 32'h2);
        check("w1c_irq_still", 32'(ch_irq), 32'h2);
        @(negedge clk);
        check("w1c_irq_clr", 32'(ch_irq), 32'h0);
        check("w1c_uart_irq_clr", 32'(uart_irq), 32'h0);
        bus_read(1, 5, rd);
        check("w1c_ris1", rd, 32'h0);

        // 4: held parity error on ch0, set beats clear; IMR=0 keeps IRQ low
        pe  = 4'b0001;
        rxe = 4'b0001;
        txf = 4'b0001;
        repeat (3) @(negedge clk);
        bus_read(0, 4, rd);
        check("sr0", rd, 32'h91);
        bus_write(0, 5, 32'h1);
        bus_read(0, 5, rd);
        check("ris0_set_wins", rd, 32'h1);
        bus_read(0, 9, rd);
        check("mis0_masked", rd, 32'h0);
        check("irq0_masked", 32'(ch_irq), 32'h0);
        check("uart_irq_masked", 32'(uart_irq), 32'h0);
        pe = 4'b0000;
        repeat (3) @(negedge clk);
        bus_write(0, 5, 32'h0);
        bus_read(0, 5, rd);
        check("ris0_w0_noeffect", rd, 32'h1);
        bus_write(0, 5, 32'h1);
        bus_read(0, 5, rd);
        check("ris0_cleared", rd, 32'h0);
        rxe = 4'b0000;
        txf = 4'b0000;

        // 5: width truncation, FCR/ER/FBRD fields, unused offsets
        bus_write(3, 7, 32'hFFFF_FFFF);
        check("ibrd3_out", 32'(ibrd_val[63:48]), 32'hFFFF);
        check("ibrd_others", 32'(ibrd_val[47:0] == 48'h0), 32'h1);
        bus_read(3, 7, rd);
        check("ibrd3_rd", rd, 32'h0000_FFFF);
        bus_write(3, 8, 32'hFF);
        bus_read(3, 8, rd);
        check("fbrd3_rd", rd, 32'h3F);
        check("fbrd3_out", 32'(fbrd_val[23:18]), 32'h3F);
        bus_write(0, 2, 32'hA5);
        check("fcr0_rx", 32'(rx_fifol[3:0]), 32'h5);
        check("fcr0_tx", 32'(tx_fifol[3:0]), 32'hA);
        bus_write(0, 3, 32'hFF);
        check("er0_en", 32'({tx_en[0], rx_en[0], uart_en[0]}), 32'h7);
        bus_write(3, 12, 32'h1234_5678);
        bus_read(3, 12, rd);
        check("offC_rd", rd, 32'h0);
        bus_write(0, 0, 32'h3F);
        bus_read(0, 0, rd);
        check("off0_rd", rd, 32'h0);
        bus_read(3, 1, rd);
        check("offC_no_lcr3", rd, 32'h0);
        bus_read(0, 1, rd);
        check("off0_no_lcr0", rd, 32'h0);

        // 6: back-to-back reads of ch0 LCR/FCR/ER
        bus_write(0, 1, 32'h15);
        @(negedge clk);
        bus.dsp_cen  = 1'b0;
        bus.dsp_wen  = 1'b1;
        bus.dsp_addr = {2'd0, 4'd1};
        @(negedge clk);
        check("b2b_lcr", bus.dsp_rdata, 32'h15);
        bus.dsp_addr = {2'd0, 4'd2};
        @(negedge clk);
        check("b2b_fcr", bus.dsp_rdata, 32'hA5);
        bus.dsp_addr = {2'd0, 4'd3};
        @(negedge clk);
        check("b2b_er", bus.dsp_rdata, 32'h7);
        bus.dsp_cen  = 1'b1;
        @(negedge clk);
        check("rdata_hold", bus.dsp_rdata, 32'h7);
        bus_write(0, 5, 32'h0);    // a write leaves DSP_RDATA alone
        check("rdata_hold_wr", bus.dsp_rdata, 32'h7);

        // Reset between write and read; pending read in the reset cycle is dropped
        bus_write(0, 1, 32'h2A);
        bus_read(0, 1, rd);
        check("pre_rst_lcr", rd, 32'h2A);
        @(negedge clk);
        bus.dsp_cen  = 1'b0;
        bus.dsp_wen  = 1'b1;
        bus.dsp_addr = {2'd0, 4'd1};
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        bus.dsp_cen = 1'b1;
        check("rst_drop_read", bus.dsp_rdata, 32'h0);
        bus_read(0, 1, rd);
        check("post_rst_lcr", rd, 32'h0);
        bus_read(3, 7, rd);
        check("post_rst_ibrd", rd, 32'h0);
        check("post_rst_data_bits", 32'(data_bits), 32'h924);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
